// File: rtl/tex_fetch_pkg.sv
// -----------------------------------------------------------------------------
// tex_fetch_pkg
// Shared types and constants for the texture fetch sequencer.
//   state_t      : sequencer state encoding
//   PF_PAL4/8    : TCW pixel formats that go through the palette RAM
//   TCW_* / ISP_*: bit positions inside the TCW / ISP words
//   is_pal_fmt() : true when a TCW selects a palette format
// -----------------------------------------------------------------------------
package tex_fetch_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    CB_START  = 3'd1,
    CB_ARM    = 3'd2,
    CB_LOAD   = 3'd3,
    ISSUE     = 3'd4,
    WAIT_DATA = 3'd5,
    SETTLE    = 3'd6,
    OUT       = 3'd7
  } state_t;

  localparam logic [2:0] PF_PAL4 = 3'd5;
  localparam logic [2:0] PF_PAL8 = 3'd6;

  localparam int TCW_VQ      = 30;
  localparam int TCW_FMT_LSB = 27;  // pixel format lives in tcw[29:27]
  localparam int ISP_TEXTURE = 25;
  localparam int CB_ADDR_W   = 21;  // code book base address is tcw[20:0]

  function automatic logic is_pal_fmt(input logic [31:0] tcw);
    logic [2:0] fmt;
    fmt = tcw[TCW_FMT_LSB +: 3];
    return (fmt == PF_PAL4) || (fmt == PF_PAL8);
  endfunction

endpackage

// File: rtl/tex_fetch_sched_if.sv
// -----------------------------------------------------------------------------
// tex_fetch_sched_if
// Pixel pipeline <-> texture fetch sequencer handshake bundle.
//   px_valid/px_ready : sample request handshake, with px_u/px_v/px_isp/px_tsp/px_tcw
//   tx_valid/tx_ready : result handshake, with tx_argb
// modport master : pixel pipeline side (issues requests, consumes results)
// modport slave  : sequencer side
// -----------------------------------------------------------------------------
interface tex_fetch_sched_if;
  logic        px_valid;
  logic        px_ready;
  logic [9:0]  px_u;
  logic [9:0]  px_v;
  logic [31:0] px_isp;
  logic [31:0] px_tsp;
  logic [31:0] px_tcw;
  logic        tx_valid;
  logic        tx_ready;
  logic [31:0] tx_argb;

  modport master (
    output px_valid, px_u, px_v, px_isp, px_tsp, px_tcw, tx_ready,
    input  px_ready, tx_valid, tx_argb
  );

  modport slave (
    input  px_valid, px_u, px_v, px_isp, px_tsp, px_tcw, tx_ready,
    output px_ready, tx_valid, tx_argb
  );
endinterface

// File: rtl/tex_cb_residency.sv
// -----------------------------------------------------------------------------
// tex_cb_residency
// Tracks which VQ code book is resident in the datapath.
//   clock, reset   : clock, synchronous active-high reset
//   i_start        : sequencer is issuing the code book load pulse
//   i_inflight     : a code book load is being started or is running
//   i_done         : the running load completes this cycle
//   i_inval        : drop residency (VRAM write / frame start)
//   i_load_addr    : code book address of the load in flight
//   i_req_addr     : code book address wanted by the incoming request
//   o_need_reload  : resident code book does not match i_req_addr
// -----------------------------------------------------------------------------
module tex_cb_residency
  import tex_fetch_pkg::*;
(
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 i_start,
  input  logic                 i_inflight,
  input  logic                 i_done,
  input  logic                 i_inval,
  input  logic [CB_ADDR_W-1:0] i_load_addr,
  input  logic [CB_ADDR_W-1:0] i_req_addr,
  output logic                 o_need_reload
);

  logic                 r_cb_valid;
  logic [CB_ADDR_W-1:0] r_cb_addr;
  logic                 r_pend_inval;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_cb_valid   <= 1'b0;
      r_cb_addr    <= '0;
      r_pend_inval <= 1'b0;
    end else begin
      // Invalidate beats a completion landing in the same cycle.
      if (i_inval)     r_cb_valid <= 1'b0;
      else if (i_done) r_cb_valid <= !r_pend_inval;

      if (i_done) r_cb_addr <= i_load_addr;

      // An invalidate during a load lets the load finish but not count.
      if (i_inval && i_inflight) r_pend_inval <= 1'b1;
      else if (i_start)          r_pend_inval <= 1'b0;
    end
  end

  assign o_need_reload = !r_cb_valid || (r_cb_addr != i_req_addr);

endmodule

// File: rtl/tex_fetch_sched.sv
// -----------------------------------------------------------------------------
// tex_fetch_sched
// Sequencer in front of the texture address/blend datapath. Accepts one sample
// request, holds it to the datapath, reloads the VQ code book when needed,
// arbitrates the VRAM read port, waits out palette latency and returns ARGB.
//   clock, reset            : clock, synchronous active-high reset
//   pix (slave)             : request / result handshakes
//   dp_ui/vi/isp/tsp/tcw    : registered request fields to the datapath
//   dp_vram_din             : live vram_din during CB_LOAD, else captured word
//   dp_vram_word_addr       : datapath fetch address (mirrored on vram_word_addr)
//   dp_final_argb           : datapath blended result
//   read_codebook           : one-cycle code book load pulse
//   codebook_wait           : datapath busy loading the code book
//   pal_wr                  : SH4 palette write holding the palette port
//   cb_invalidate           : drop code book residency
//   vram_rd/vram_word_addr  : VRAM read request, vram_wait back-pressure
//   vram_valid/vram_din     : VRAM read return
// Optional: define TEX_FETCH_LASTWORD_EN for a one-entry last-word buffer that
// skips a VRAM read when the fetch address repeats.
// -----------------------------------------------------------------------------
module tex_fetch_sched
  import tex_fetch_pkg::*;
#(
  parameter int ADDR_W   = 21,
  parameter int PAL_LAT  = 1,
  parameter int CB_WORDS = 256
) (
  input  logic              clock,
  input  logic              reset,
  tex_fetch_sched_if.slave  pix,
  output logic [9:0]        dp_ui,
  output logic [9:0]        dp_vi,
  output logic [31:0]       dp_isp,
  output logic [31:0]       dp_tsp,
  output logic [31:0]       dp_tcw,
  output logic [63:0]       dp_vram_din,
  input  logic [ADDR_W-1:0] dp_vram_word_addr,
  input  logic [31:0]       dp_final_argb,
  output logic              read_codebook,
  input  logic              codebook_wait,
  input  logic              pal_wr,
  input  logic              cb_invalidate,
  output logic              vram_rd,
  output logic [ADDR_W-1:0] vram_word_addr,
  input  logic              vram_wait,
  input  logic              vram_valid,
  input  logic [63:0]       vram_din
);

  if (PAL_LAT < 0 || CB_WORDS < 1) begin : g_param_check
    $error("tex_fetch_sched: PAL_LAT must be >= 0 and CB_WORDS >= 1");
  end

  localparam int CNT_W = (PAL_LAT < 2) ? 1 : $clog2(PAL_LAT + 1);
  localparam logic [CNT_W-1:0] PAL_CNT = CNT_W'(PAL_LAT);

  state_t           r_state;
  logic [9:0]       r_dp_ui;
  logic [9:0]       r_dp_vi;
  logic [31:0]      r_dp_isp;
  logic [31:0]      r_dp_tsp;
  logic [31:0]      r_dp_tcw;
  logic [63:0]      r_data_q;
  logic [31:0]      r_tx_argb;
  logic [CNT_W-1:0] r_cnt;

  logic             w_need_reload;
  logic             w_pal;
  logic [CNT_W-1:0] w_settle_init;
  logic             w_lw_hit;

  assign w_pal         = is_pal_fmt(r_dp_tcw);
  assign w_settle_init = w_pal ? PAL_CNT : '0;

  tex_cb_residency u_cb_res (
    .clock         (clock),
    .reset         (reset),
    .i_start       (r_state == CB_START),
    .i_inflight    (r_state == CB_START || r_state == CB_ARM || r_state == CB_LOAD),
    .i_done        (r_state == CB_LOAD && !codebook_wait),
    .i_inval       (cb_invalidate),
    .i_load_addr   (r_dp_tcw[CB_ADDR_W-1:0]),
    .i_req_addr    (pix.px_tcw[CB_ADDR_W-1:0]),
    .o_need_reload (w_need_reload)
  );

  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (reset) begin
      r_state   <= IDLE;
      r_dp_ui   <= '0;
      r_dp_vi   <= '0;
      r_dp_isp  <= '0;
      r_dp_tsp  <= '0;
      r_dp_tcw  <= '0;
      r_data_q  <= '0;
      r_tx_argb <= '0;
      r_cnt     <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (pix.px_valid) begin
            r_dp_ui  <= pix.px_u;
            r_dp_vi  <= pix.px_v;
            r_dp_isp <= pix.px_isp;
            r_dp_tsp <= pix.px_tsp;
            r_dp_tcw <= pix.px_tcw;
            if (!pix.px_isp[ISP_TEXTURE]) begin
              r_state <= SETTLE;
              r_cnt   <= '0;
            end else if (pix.px_tcw[TCW_VQ] && w_need_reload) begin
              r_state <= CB_START;
            end else begin
              r_state <= ISSUE;
            end
          end
        end
        CB_START: r_state <= CB_ARM;
        // A datapath that never raised codebook_wait did not start a load.
        CB_ARM:   r_state <= codebook_wait ? CB_LOAD : ISSUE;
        CB_LOAD:  if (!codebook_wait) r_state <= ISSUE;
        ISSUE: begin
          if (w_lw_hit) begin
            r_state <= SETTLE;
            r_cnt   <= w_settle_init;
          end else if (!vram_wait) begin
            r_state <= WAIT_DATA;
          end
        end
        WAIT_DATA: begin
          if (vram_valid) begin
            r_data_q <= vram_din;
            r_state  <= SETTLE;
            r_cnt    <= w_settle_init;
          end
        end
        SETTLE: begin
          // A palette write steals the palette port, so restart the wait.
          if (pal_wr && w_pal) begin
            r_cnt <= PAL_CNT;
          end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
          end else if (!pal_wr) begin
            r_tx_argb <= dp_final_argb;
            r_state   <= OUT;
          end
        end
        OUT:     if (pix.tx_ready) r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef TEX_FETCH_LASTWORD_EN
  logic              r_last_valid;
  logic [ADDR_W-1:0] r_last_addr;

  always_ff @(posedge clock) begin
    if (reset || cb_invalidate || r_state == CB_LOAD) r_last_valid <= 1'b0;
    else if (r_state == WAIT_DATA && vram_valid)      r_last_valid <= 1'b1;

    if (reset)                                   r_last_addr <= '0;
    else if (r_state == WAIT_DATA && vram_valid) r_last_addr <= dp_vram_word_addr;
  end

  // data_q still holds the word at r_last_addr, so the read can be skipped.
  assign w_lw_hit = (r_state == ISSUE) && r_last_valid && (dp_vram_word_addr == r_last_addr);
`else
  assign w_lw_hit = 1'b0;
`endif

  always_comb begin
    // NOTE: default assignment first keeps this block free of inferred latches.
    vram_rd = 1'b0;
    case (r_state)
      CB_LOAD: vram_rd = codebook_wait;
      ISSUE:   vram_rd = !w_lw_hit;
      default: vram_rd = 1'b0;
    endcase
  end

  assign pix.px_ready   = (r_state == IDLE);
  assign pix.tx_valid   = (r_state == OUT);
  assign pix.tx_argb    = r_tx_argb;
  assign read_codebook  = (r_state == CB_START);
  assign vram_word_addr = dp_vram_word_addr;
  assign dp_vram_din    = (r_state == CB_LOAD) ? vram_din : r_data_q;
  assign dp_ui          = r_dp_ui;
  assign dp_vi          = r_dp_vi;
  assign dp_isp         = r_dp_isp;
  assign dp_tsp         = r_dp_tsp;
  assign dp_tcw         = r_dp_tcw;

endmodule

// File: tb/tb_tex_fetch_sched.sv
// -----------------------------------------------------------------------------
// tb_tex_fetch_sched
// Bench for tex_fetch_sched with a small datapath model (address + blend),
// a VRAM responder, a code book loader and an expected-ARGB queue.
// -----------------------------------------------------------------------------
module tb_tex_fetch_sched;

  localparam int ADDR_W   = 21;
  localparam int PAL_LAT  = 1;
  localparam int CB_WORDS = 256;
  localparam logic [31:0] ISP_TEX = 32'h0200_0000;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  tex_fetch_sched_if pix ();

  logic [9:0]        dp_ui, dp_vi;
  logic [31:0]       dp_isp, dp_tsp, dp_tcw;
  logic [63:0]       dp_vram_din;
  logic [ADDR_W-1:0] dp_vram_word_addr, vram_word_addr;
  logic [31:0]       dp_final_argb;
  logic              read_codebook, codebook_wait, pal_wr, cb_invalidate;
  logic              vram_rd, vram_wait, vram_valid;
  logic [63:0]       vram_din;

  tex_fetch_sched #(.ADDR_W(ADDR_W), .PAL_LAT(PAL_LAT), .CB_WORDS(CB_WORDS)) dut (
    .clock             (clock),
    .reset             (reset),
    .pix               (pix),
    .dp_ui             (dp_ui),
    .dp_vi             (dp_vi),
    .dp_isp            (dp_isp),
    .dp_tsp            (dp_tsp),
    .dp_tcw            (dp_tcw),
    .dp_vram_din       (dp_vram_din),
    .dp_vram_word_addr (dp_vram_word_addr),
    .dp_final_argb     (dp_final_argb),
    .read_codebook     (read_codebook),
    .codebook_wait     (codebook_wait),
    .pal_wr            (pal_wr),
    .cb_invalidate     (cb_invalidate),
    .vram_rd           (vram_rd),
    .vram_word_addr    (vram_word_addr),
    .vram_wait         (vram_wait),
    .vram_valid        (vram_valid),
    .vram_din          (vram_din)
  );

  // ---------------- environment models ----------------
  function automatic logic [ADDR_W-1:0] addr_of(input logic [9:0] u, input logic [9:0] v,
                                                input logic [31:0] tcw);
    return tcw[20:0] + ADDR_W'(u[9:2]) + (ADDR_W'(v) << 6);
  endfunction

  function automatic logic [63:0] mem_word(input logic [ADDR_W-1:0] a);
    return {11'h5A5, a, 32'(a) * 32'h9E37_79B9};
  endfunction

  assign dp_vram_word_addr = addr_of(dp_ui, dp_vi, dp_tcw);
  assign dp_final_argb     = dp_isp[25] ? (dp_vram_din[31:0] ^ dp_tsp) : dp_tsp;

  int cyc = 0;
  int tests_run = 0;
  int tests_failed = 0;

  // VRAM: accepted read returns data the next cycle unless held back.
  logic              rsp_pend = 1'b0;
  logic [ADDR_W-1:0] rsp_addr = '0;
  logic              hold_rsp = 1'b0;
  logic              late_beat = 1'b0;
  int                n_wait_seen = 0;
  int                wait_target = 0;
  assign vram_wait  = vram_rd && (n_wait_seen < wait_target);
  assign vram_valid = rsp_pend | late_beat;
  assign vram_din   = mem_word(rsp_addr);

  // Code book loader: codebook_wait high CB_WORDS cycles after the pulse.
  int   cb_cnt = 0;
  logic inval_arm = 1'b0;
  assign codebook_wait = (cb_cnt != 0);
  assign cb_invalidate = inval_arm && (cb_cnt == 100);

  int pal_from = -100;
  assign pal_wr = (cyc >= pal_from) && (cyc < pal_from + 3);

  int                n_rd = 0, n_rd_cb = 0, n_cb_pulse = 0, n_addr_chg = 0;
  logic              prev_rd = 1'b0;
  logic [ADDR_W-1:0] prev_addr = '0;

  always @(posedge clock) begin
    cyc      <= cyc + 1;
    rsp_pend <= vram_rd && !vram_wait && !hold_rsp;
    rsp_addr <= vram_word_addr;
    if (vram_wait) n_wait_seen <= n_wait_seen + 1;
    if (read_codebook)   cb_cnt <= CB_WORDS;
    else if (cb_cnt > 0) cb_cnt <= cb_cnt - 1;
    if (vram_rd) n_rd <= n_rd + 1;
    if (vram_rd && codebook_wait) n_rd_cb <= n_rd_cb + 1;
    if (read_codebook) n_cb_pulse <= n_cb_pulse + 1;
    if (vram_rd && prev_rd && vram_word_addr != prev_addr) n_addr_chg <= n_addr_chg + 1;
    prev_rd   <= vram_rd;
    prev_addr <= vram_word_addr;
  end

  // ---------------- scoreboard + handshake tasks ----------------
  logic [31:0] exp_q[$];
  int          t_acc;

  task automatic send(input logic [9:0] u, input logic [9:0] v,
                      input logic [31:0] isp, input logic [31:0] tsp, input logic [31:0] tcw);
    logic [63:0] w;
    @(negedge clock);
    pix.px_valid = 1'b1;
    pix.px_u = u; pix.px_v = v; pix.px_isp = isp; pix.px_tsp = tsp; pix.px_tcw = tcw;
    for (int i = 0; i < 1000 && !pix.px_ready; i++) @(negedge clock);
    if (!pix.px_ready) begin
      tests_run++; tests_failed++;
      $display("FAIL accept_timeout: px_ready stayed 0, required 1");
    end
    t_acc = cyc;
    w = mem_word(addr_of(u, v, tcw));
    exp_q.push_back(isp[25] ? (w[31:0] ^ tsp) : tsp);
    @(negedge clock);
    pix.px_valid = 1'b0;
  endtask

  task automatic recv(input string name, input int exp_lat, input int stall);
    int          lat;
    logic [31:0] e;
    logic        stable;
    pix.tx_ready = (stall == 0);
    for (int i = 0; i < 2000 && !pix.tx_valid; i++) @(negedge clock);
    if (!pix.tx_valid) begin
      tests_run++; tests_failed++;
      $display("FAIL %s tx_timeout: tx_valid stayed 0, required 1", name);
      pix.tx_ready = 1'b1;
      return;
    end
    lat = cyc - t_acc;
    e = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
    if (exp_lat >= 0) begin
      tests_run++;
      if (lat !== exp_lat) begin
        tests_failed++;
        $display("FAIL %s latency: got T+%0d required T+%0d", name, lat, exp_lat);
      end
    end
    tests_run++;
    if (pix.tx_argb !== e) begin
      tests_failed++;
      $display("FAIL %s argb: got %h required %h", name, pix.tx_argb, e);
    end
    if (stall > 0) begin
      stable = 1'b1;
      repeat (stall) begin
        @(negedge clock);
        if (pix.tx_argb !== e || !pix.tx_valid || pix.px_ready) stable = 1'b0;
      end
      tests_run++;
      if (stable !== 1'b1) begin
        tests_failed++;
        $display("FAIL %s stall_hold: argb=%h valid=%b px_ready=%b, required %h/1/0",
                 name, pix.tx_argb, pix.tx_valid, pix.px_ready, e);
      end
      pix.tx_ready = 1'b1;
    end
    @(negedge clock);
    tests_run++;
    if (pix.px_ready !== 1'b1 || pix.tx_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL %s return_idle: px_ready=%b tx_valid=%b, required 1/0",
               name, pix.px_ready, pix.tx_valid);
    end
  endtask

  task automatic check_reset_outputs(input string name);
    tests_run++;
    if (pix.px_ready !== 1'b1 || pix.tx_valid !== 1'b0 || vram_rd !== 1'b0 ||
        read_codebook !== 1'b0) begin
      tests_failed++;
      $display("FAIL %s ctrl: px_ready=%b tx_valid=%b vram_rd=%b read_codebook=%b, required 1/0/0/0",
               name, pix.px_ready, pix.tx_valid, vram_rd, read_codebook);
    end
    tests_run++;
    if (pix.tx_argb !== 32'h0) begin
      tests_failed++;
      $display("FAIL %s tx_argb: got %h required 0", name, pix.tx_argb);
    end
    tests_run++;
    if ({dp_ui, dp_vi, dp_isp, dp_tsp, dp_tcw} !== '0) begin
      tests_failed++;
      $display("FAIL %s dp_regs: ui=%h vi=%h isp=%h tsp=%h tcw=%h, required all 0",
               name, dp_ui, dp_vi, dp_isp, dp_tsp, dp_tcw);
    end
    tests_run++;
    if (dp_vram_din !== 64'h0) begin
      tests_failed++;
      $display("FAIL %s data_q: got %h required 0", name, dp_vram_din);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clock);
    check_reset_outputs("reset");
    reset = 1'b0;
  endtask

  task automatic test_untextured();
    int r0;
    r0 = n_rd;
    send(10'd3, 10'd4, 32'h0, 32'h1234_5678, 32'h0000_1000);
    recv("untextured", 2, 0);
    tests_run++;
    if (n_rd - r0 !== 0) begin
      tests_failed++;
      $display("FAIL untextured vram_rd: got %0d cycles required 0", n_rd - r0);
    end
  endtask

  task automatic test_texel16();
    int r0;
    r0 = n_rd;
    send(10'd8, 10'd2, ISP_TEX, 32'h0F0F_0000, 32'h0800_0400);
    recv("texel16", 4, 0);
    tests_run++;
    if (n_rd - r0 !== 1) begin
      tests_failed++;
      $display("FAIL texel16 vram_rd: got %0d cycles required 1", n_rd - r0);
    end
  endtask

  task automatic test_vq();
    int p0, r0, c0;
    p0 = n_cb_pulse; r0 = n_rd; c0 = n_rd_cb;
    send(10'd12, 10'd1, ISP_TEX, 32'h00AA_5500, 32'h4800_1000);
    recv("vq_cold", -1, 0);
    tests_run++;
    if (n_cb_pulse - p0 !== 1) begin
      tests_failed++;
      $display("FAIL vq_cold pulses: got %0d required 1", n_cb_pulse - p0);
    end
    // The first codebook_wait cycle is the arm cycle, where vram_rd stays low.
    tests_run++;
    if (n_rd_cb - c0 !== CB_WORDS - 1) begin
      tests_failed++;
      $display("FAIL vq_cold cb_reads: got %0d required %0d", n_rd_cb - c0, CB_WORDS - 1);
    end
    tests_run++;
    if ((n_rd - r0) - (n_rd_cb - c0) !== 1) begin
      tests_failed++;
      $display("FAIL vq_cold texel_reads: got %0d required 1", (n_rd - r0) - (n_rd_cb - c0));
    end
    p0 = n_cb_pulse;
    send(10'd16, 10'd1, ISP_TEX, 32'h00AA_5501, 32'h4800_1000);
    recv("vq_warm", 4, 0);
    tests_run++;
    if (n_cb_pulse - p0 !== 0) begin
      tests_failed++;
      $display("FAIL vq_warm pulses: got %0d required 0", n_cb_pulse - p0);
    end
  endtask

  task automatic test_cb_invalidate();
    int p0;
    p0 = n_cb_pulse;
    inval_arm = 1'b1;
    send(10'd20, 10'd1, ISP_TEX, 32'h1111_0000, 32'h4800_2000);
    recv("inval_load", -1, 0);
    inval_arm = 1'b0;
    p0 = n_cb_pulse;
    send(10'd24, 10'd1, ISP_TEX, 32'h1111_0001, 32'h4800_2000);
    recv("inval_reload", -1, 0);
    tests_run++;
    if (n_cb_pulse - p0 !== 1) begin
      tests_failed++;
      $display("FAIL inval_reload pulses: got %0d required 1", n_cb_pulse - p0);
    end
    p0 = n_cb_pulse;
    send(10'd28, 10'd1, ISP_TEX, 32'h1111_0002, 32'h4800_2000);
    recv("inval_resident", 4, 0);
    tests_run++;
    if (n_cb_pulse - p0 !== 0) begin
      tests_failed++;
      $display("FAIL inval_resident pulses: got %0d required 0", n_cb_pulse - p0);
    end
  endtask

  task automatic test_pal8();
    send(10'd4, 10'd3, ISP_TEX, 32'h2222_0000, 32'h3000_0800);
    recv("pal8_plain", 4 + PAL_LAT, 0);
    send(10'd4, 10'd7, ISP_TEX, 32'h2222_0001, 32'h3000_0800);
    pal_from = t_acc + 3;  // first SETTLE cycle
    recv("pal8_palwr", 4 + PAL_LAT + 3, 0);
    pal_from = -100;
  endtask

  task automatic test_wait_stall();
    int r0, a0;
    r0 = n_rd; a0 = n_addr_chg;
    wait_target = n_wait_seen + 5;
    send(10'd40, 10'd2, ISP_TEX, 32'h3333_0000, 32'h0800_0400);
    recv("wait_stall", 4 + 5, 4);
    tests_run++;
    if (n_rd - r0 !== 6) begin
      tests_failed++;
      $display("FAIL wait_stall vram_rd: got %0d cycles required 6", n_rd - r0);
    end
    tests_run++;
    if (n_addr_chg - a0 !== 0) begin
      tests_failed++;
      $display("FAIL wait_stall addr_hold: got %0d changes required 0", n_addr_chg - a0);
    end
  endtask

  task automatic test_lastword();
    int r0;
    send(10'd0, 10'd5, ISP_TEX, 32'h4444_0000, 32'h0800_3000);
    recv("lastword_first", 4, 0);
    r0 = n_rd;
    send(10'd1, 10'd5, ISP_TEX, 32'h4444_0001, 32'h0800_3000);
`ifdef TEX_FETCH_LASTWORD_EN
    recv("lastword_hit", 3, 0);
    tests_run++;
    if (n_rd - r0 !== 0) begin
      tests_failed++;
      $display("FAIL lastword_hit vram_rd: got %0d cycles required 0", n_rd - r0);
    end
`else
    recv("lastword_off", 4, 0);
    tests_run++;
    if (n_rd - r0 !== 1) begin
      tests_failed++;
      $display("FAIL lastword_off vram_rd: got %0d cycles required 1", n_rd - r0);
    end
`endif
  endtask

  task automatic test_reset_mid();
    hold_rsp = 1'b1;
    send(10'd44, 10'd9, ISP_TEX, 32'h5555_0000, 32'h0800_0400);
    @(negedge clock);  // now in WAIT_DATA with the read outstanding
    reset = 1'b1;
    @(negedge clock);
    check_reset_outputs("reset_mid");
    reset = 1'b0;
    hold_rsp = 1'b0;
    exp_q.delete();
    late_beat = 1'b1;
    @(negedge clock);
    late_beat = 1'b0;
    @(negedge clock);
    tests_run++;
    if (dp_vram_din !== 64'h0 || pix.px_ready !== 1'b1 || pix.tx_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL late_beat: data_q=%h px_ready=%b tx_valid=%b, required 0/1/0",
               dp_vram_din, pix.px_ready, pix.tx_valid);
    end
    send(10'd5, 10'd5, 32'h0, 32'hCAFE_F00D, 32'h0);
    recv("after_reset", 2, 0);
  endtask

  initial begin
    reset = 1'b1;
    pix.px_valid = 1'b0;
    pix.px_u = '0; pix.px_v = '0;
    pix.px_isp = '0; pix.px_tsp = '0; pix.px_tcw = '0;
    pix.tx_ready = 1'b1;
    test_reset();
    test_untextured();
    test_texel16();
    test_vq();
    test_cb_invalidate();
    test_pal8();
    test_wait_stall();
    test_lastword();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

endmodule
